// File: rtl/packet_pkg.sv
// Shared packet types for the switch datapath: field widths, the packet
// record carried through the ingress FIFO, and the ingress FSM states.
package packet_pkg;

  localparam int NUM_PORTS = 4;
  localparam int SRC_W     = 4;
  localparam int TGT_W     = 4;
  localparam int DATA_W    = 8;
  localparam int PKT_W     = SRC_W + TGT_W + DATA_W;

  typedef logic [NUM_PORTS-1:0] port_mask_t;

  typedef struct packed {
    logic [SRC_W-1:0]  source;
    logic [TGT_W-1:0]  target;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic {
    EMPTY = 1'b0,
    SERVE = 1'b1
  } ingress_state_e;

endpackage

// File: rtl/switch_sync_fifo.sv
// Single-clock FIFO for the ingress path. Besides the head entry it also
// exposes the entry behind the head so the consumer can preload its next
// request in the same edge that pops the current one.
module switch_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_rd_data,
  output logic [W-1:0]  o_rd_next,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [AW-1:0] w_rptr_inc;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign w_rptr_inc = r_rptr + 1'b1;
  assign o_rd_data  = r_mem[r_rptr];
  assign o_rd_next  = r_mem[w_rptr_inc];

  // Pop only real data; a push into a full FIFO needs the same-edge pop
  // to free the slot it lands in.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are qualified by the level so no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers wrap naturally at DEPTH (power of 2); level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= w_rptr_inc;
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

endmodule

// File: rtl/switch_port_ingress.sv
// Receive side of one switch port: accepts single-cycle packet strobes,
// queues them, and serves the head packet to the crossbar as a request
// mask whose bits retire as grants arrive (multicast in one or more steps).
// Optional source checking is enabled with SWITCH_PORT_INGRESS_SRC_CHECK_EN,
// which adds the src_err output.
module switch_port_ingress #(
  parameter int PORT_ID   = 0,
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [3:0]             source_in,
  input  logic [3:0]             target_in,
  input  logic [7:0]             data_in,
  output logic [NUM_PORTS-1:0]   req,
  output logic [3:0]             head_source,
  output logic [3:0]             head_target,
  output logic [7:0]             head_data,
  input  logic [NUM_PORTS-1:0]   grant,
  output logic [$clog2(DEPTH):0] fifo_level,
`ifdef SWITCH_PORT_INGRESS_SRC_CHECK_EN
  output logic                   src_err,
`endif
  output logic [7:0]             drop_cnt
);

  import packet_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  // Catch bad configurations at elaboration rather than in silicon.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("switch_port_ingress: DEPTH must be a power of 2 and >= 2");
  end
  if (PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_bad_port
    $error("switch_port_ingress: PORT_ID out of range");
  end

  ingress_state_e r_state;
  ingress_state_e w_state_nxt;
  port_mask_t     r_pending;
  pkt_t           r_last;
  logic [7:0]     r_drop_cnt;

  pkt_t           w_pkt;
  pkt_t           w_rd_data;
  pkt_t           w_rd_next;
  logic           w_full;
  logic           w_empty;
  logic [LW-1:0]  w_level;
  port_mask_t     w_rem;
  logic           w_pop;
  logic           w_src_ok;
  logic           w_cand;
  logic           w_push;
  logic           w_drop;
  pkt_t           w_head;
  port_mask_t     w_req;

  assign w_pkt = '{source: source_in, target: target_in, data: data_in};

`ifdef SWITCH_PORT_INGRESS_SRC_CHECK_EN
  logic r_src_err;
  assign w_src_ok = (source_in == (port_mask_t'(1) << PORT_ID));
  assign src_err  = r_src_err;

  // One-cycle error pulse following a strobe from the wrong source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_src_err <= 1'b0;
    else        r_src_err <= valid_in && !w_src_ok;
  end
`else
  assign w_src_ok = 1'b1;
`endif

  // Head retires once every outstanding destination is granted; grant bits
  // outside the pending mask fall out of the AND-NOT.
  assign w_rem  = r_pending & ~grant;
  assign w_pop  = (r_state == SERVE) && (w_rem == '0);
  assign w_cand = valid_in && (target_in != '0) && w_src_ok;
  assign w_push = w_cand && (!w_full || w_pop);
  assign w_drop = valid_in && !w_push;

  switch_sync_fifo #(
    .W     (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_din     (w_pkt),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_rd_next (w_rd_next),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave SERVE only when the last entry pops with no refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = SERVE;
      SERVE: if (w_pop && !w_push && (w_level == LW'(1))) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Outputs: request and head only meaningful while serving; head holds
  // the last served packet when idle.
  always_comb begin
    w_req  = '0;
    w_head = r_last;
    if (r_state == SERVE && !w_empty) begin
      w_req  = r_pending;
      w_head = w_rd_data;
    end
  end

  // Pending mask: retire granted bits, and on a pop preload the next head's
  // target (queued entry, else the packet arriving this edge) so there is
  // no idle cycle between packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_last    <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_push) r_pending <= target_in;
        SERVE: begin
          if (w_pop) begin
            r_last <= w_rd_data;
            if (w_level > LW'(1)) r_pending <= w_rd_next.target;
            else if (w_push)      r_pending <= target_in;
            else                  r_pending <= '0;
          end else begin
            r_pending <= w_rem;
          end
        end
        default: r_pending <= '0;
      endcase
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign req         = w_req;
  assign head_source = w_head.source;
  assign head_target = w_head.target;
  assign head_data   = w_head.data;
  assign fifo_level  = w_level;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_switch_port_ingress.sv
// Directed bench for switch_port_ingress (PORT_ID=0, DEPTH=4).
module tb_switch_port_ingress;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] source_in;
  logic [3:0] target_in;
  logic [7:0] data_in;
  logic [3:0] req;
  logic [3:0] head_source;
  logic [3:0] head_target;
  logic [7:0] head_data;
  logic [3:0] grant;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;
`ifdef SWITCH_PORT_INGRESS_SRC_CHECK_EN
  logic       src_err;
`endif

  int errors = 0;
  int checks = 0;

  switch_port_ingress #(
    .PORT_ID   (0),
    .NUM_PORTS (4),
    .DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .source_in   (source_in),
    .target_in   (target_in),
    .data_in     (data_in),
    .req         (req),
    .head_source (head_source),
    .head_target (head_target),
    .head_data   (head_data),
    .grant       (grant),
    .fifo_level  (fifo_level),
`ifdef SWITCH_PORT_INGRESS_SRC_CHECK_EN
    .src_err     (src_err),
`endif
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    valid_in  = 1'b1;
    source_in = s;
    target_in = t;
    data_in   = d;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; source_in = '0; target_in = '0;
    data_in = '0; grant = '0;
    #3;
    chk("rst_req",   req,        0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop",  drop_cnt,   0);
    chk("rst_hdata", head_data,  0);
    #9 rst_n = 1'b1;
    tick();

    // Single unicast
    strobe(4'b0001, 4'b0100, 8'hA5);
    tick();
    valid_in = 1'b0;
    chk("uni_req",   req,         4'b0100);
    chk("uni_hdata", head_data,   8'hA5);
    chk("uni_hsrc",  head_source, 4'b0001);
    chk("uni_htgt",  head_target, 4'b0100);
    chk("uni_level", fifo_level,  1);
    grant = 4'b0100;
    tick();
    grant = '0;
    chk("uni_req_done",   req,        0);
    chk("uni_level_done", fifo_level, 0);
    chk("uni_hold_hdata", head_data,  8'hA5);

    // Multicast split grant; stray grant bit 0001 must be ignored
    strobe(4'b0001, 4'b1110, 8'h3C);
    tick();
    valid_in = 1'b0;
    chk("mc_req0", req, 4'b1110);
    grant = 4'b0011;
    tick();
    chk("mc_req1",   req,        4'b1100);
    chk("mc_level1", fifo_level, 1);
    grant = 4'b1100;
    tick();
    grant = '0;
    chk("mc_req2",   req,        0);
    chk("mc_level2", fifo_level, 0);

    // Grant while empty does nothing
    grant = 4'b1111;
    tick();
    grant = '0;
    chk("empty_grant_req",   req,        0);
    chk("empty_grant_level", fifo_level, 0);

    // Overflow: five strobes, fifth dropped
    for (int i = 1; i <= 5; i++) begin
      strobe(4'b0001, 4'b0001, 8'(i));
      tick();
    end
    valid_in = 1'b0;
    chk("ovf_level", fifo_level, 4);
    chk("ovf_drop",  drop_cnt,   1);
    chk("ovf_req",   req,        4'b0001);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", head_data, i);
      grant = 4'b0001;
      tick();
    end
    grant = '0;
    chk("ovf_drained", fifo_level, 0);

    // Full FIFO with same-edge pop accepts the new packet
    for (int i = 0; i < 4; i++) begin
      strobe(4'b0001, 4'b0010, 8'h10 + 8'(i));
      tick();
    end
    chk("fp_level_full", fifo_level, 4);
    strobe(4'b0001, 4'b0010, 8'h14);
    grant = 4'b0010;
    tick();
    valid_in = 1'b0;
    grant = '0;
    chk("fp_level", fifo_level, 4);
    chk("fp_drop",  drop_cnt,   1);
    chk("fp_head",  head_data,  8'h11);
    for (int i = 1; i <= 4; i++) begin
      chk("fp_order", head_data, 8'h10 + 8'(i));
      grant = 4'b0010;
      tick();
    end
    grant = '0;
    chk("fp_drained", fifo_level, 0);

    // Zero target drop and saturation
    strobe(4'b0001, 4'b0000, 8'h55);
    tick();
    valid_in = 1'b0;
    chk("zt_drop",  drop_cnt,   2);
    chk("zt_req",   req,        0);
    chk("zt_level", fifo_level, 0);
    strobe(4'b0001, 4'b0000, 8'h55);
    for (int i = 0; i < 300; i++) tick();
    valid_in = 1'b0;
    chk("sat_drop", drop_cnt, 255);

    // Asynchronous reset mid-multicast
    strobe(4'b0001, 4'b1000, 8'h77);
    tick();
    valid_in = 1'b0;
    chk("mr_req_pre", req, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req",   req,        0);
    chk("mr_level", fifo_level, 0);
    chk("mr_drop",  drop_cnt,   0);
    chk("mr_hdata", head_data,  0);
    #2 rst_n = 1'b1;
    tick();
    strobe(4'b0001, 4'b0001, 8'h99);
    tick();
    valid_in = 1'b0;
    chk("post_rst_req",   req,       4'b0001);
    chk("post_rst_hdata", head_data, 8'h99);
    grant = 4'b0001;
    tick();
    grant = '0;
    chk("post_rst_level", fifo_level, 0);

`ifdef SWITCH_PORT_INGRESS_SRC_CHECK_EN
    strobe(4'b0010, 4'b0001, 8'hEE);
    tick();
    valid_in = 1'b0;
    chk("src_err_pulse", src_err,    1);
    chk("src_err_drop",  drop_cnt,   1);
    chk("src_err_level", fifo_level, 0);
    tick();
    chk("src_err_clear", src_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_port_ingress.md
Name: switch_port_ingress

Overview:
- Receive side of one switch port. Samples the port's valid_in/source_in/target_in/data_in bus; the testbench transmitter drives a packet for exactly one cycle.
- Buffers accepted packets in a small FIFO.
- Presents the head packet to the crossbar arbiter as a per-destination request vector. Multicast is served by a grant handshake that retires destinations one or more at a time.
- Instantiated once per port inside the 4-port switch.

Parameters:
- PORT_ID, 0, index of this port (0..NUM_PORTS-1).
- NUM_PORTS, 4, number of switch ports; equals the width of the target/source masks.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  switch clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  packet strobe; one cycle per packet.
- source_in  input  4  source port one-hot mask.
- target_in  input  4  destination port mask; multicast allowed.
- data_in  input  8  payload.
- req  output  NUM_PORTS  outstanding destinations of the head packet.
- head_source  output  4  head packet source.
- head_target  output  4  head packet original target mask.
- head_data  output  8  head packet payload.
- grant  input  NUM_PORTS  arbiter grant, one bit per destination; the grant transfers that copy this cycle.
- fifo_level  output  $clog2(DEPTH)+1  occupancy.
- drop_cnt  output  8  saturating count of dropped packets.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values: req=0, head_*=0, fifo_level=0, drop_cnt=0, FSM=EMPTY, pending mask=0. Reset mid-operation discards FIFO contents and any partially served multicast.
- Accept: valid_in high at a posedge with target_in!=0 writes one entry. A write is allowed if level<DEPTH, or if level==DEPTH and the head pops at the same edge.
- Drop: valid_in with a full FIFO and no pop, or with target_in==0, drops the packet. drop_cnt increments by 1 and saturates at 255.
- Latency: a packet accepted at edge N into an empty FIFO shows head_* and req=target in the cycle after edge N.
- FSM states:
  - EMPTY: req=0, head_* hold their last value. Goes to SERVE on a write.
  - SERVE: pending loaded from the head target. req=pending.
    - Each edge: pending <= pending & ~grant.
    - When (pending & ~grant)==0 the head pops at that edge, and pending loads the next head's target in the same edge, so there is no bubble cycle.
    - Goes to EMPTY if the pop empties the FIFO and there is no simultaneous write.
- Grant bits outside req are ignored and do not affect state.
- grant while in EMPTY is ignored.
- Simultaneous write and pop: level is unchanged. The written packet queues behind the new head, or becomes the new head if it was the only entry.
- Write pointer and read pointer wrap modulo DEPTH. Level arithmetic is width $clog2(DEPTH)+1 and never overflows.
- req is registered, not combinational from grant.

Optional Feature:
- Macro: SWITCH_PORT_INGRESS_SRC_CHECK_EN.
- Defined: a packet with source_in != (1<<PORT_ID) is dropped and counted in drop_cnt. Added output src_err (1-bit) pulses for one cycle, one cycle after the offending strobe.
- Undefined: source_in is not checked, and src_err does not exist.

Decomposition:
- packet_pkg holds:
  - NUM_PORTS.
  - Field widths: SRC_W=4, TGT_W=4, DATA_W=8.
  - port_mask_t.
  - A packed struct pkt_t {source, target, data}.
  - The FSM enum ingress_state_e {EMPTY, SERVE}.
- Sub-module: switch_sync_fifo, parameterised on width and DEPTH. It provides push/pop/full/empty/level and stores pkt_t.

Test Plan:
- Single unicast: PORT_ID=0, drive {src=0001, tgt=0100, data=8'hA5}. Expected: next cycle req=0100 and head_data=A5. Grant 0100 for one cycle. Expected: req=0 and level=0 the following cycle.
- Multicast split grant: tgt=1110, data=3C. Grant 0010, then 1100 over two cycles. Expected: req goes 1110 -> 1100 -> 0000, with one pop on the second grant edge.
- Overflow: DEPTH=4, five back-to-back strobes, no grants. Expected: level=4, drop_cnt=1, entries 1-4 retained in order.
- Full plus simultaneous pop: FIFO full, head fully granted on the same edge as a new strobe. Expected: the packet is accepted, level stays 4, drop_cnt is unchanged.
- Invalid target and saturation: tgt=0000 strobe gives drop_cnt+1 and no req. 300 such drops give drop_cnt=255.
- Reset mid-multicast: assert rst_n=0 asynchronously while req=1000 is pending. Expected: req=0, level=0 immediately. With SWITCH_PORT_INGRESS_SRC_CHECK_EN defined, src=0010 on PORT_ID=0 gives src_err=1 and drop_cnt+1.
